// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel integer clock divider.
// Ratios wider than WIDTH_MAX are not supported by high_len.
`timescale 1ns/1ps
package clk_div_pkg;
    localparam int WIDTH_DEFAULT = 8;
    localparam int WIDTH_MAX     = 32;

    typedef enum logic {
        BYPASS = 1'b0,
        RUN    = 1'b1
    } chan_state_t;

    // Length of the high phase: ceil(r/2), so odd ratios get the extra high cycle.
    function automatic logic [WIDTH_MAX-1:0] high_len(input logic [WIDTH_MAX-1:0] r);
        return (r >> 1) + {{(WIDTH_MAX-1){1'b0}}, r[0]};
    endfunction
endpackage

// File: rtl/clk_div_multi_if.sv
// Control and output bundle of the multi-channel clock divider.
`timescale 1ns/1ps
interface clk_div_multi_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    // No handshake: enable, ratio and sync are level/pulse controls sampled on
    // every reference edge; outputs are valid every cycle.
    logic [CHANNELS-1:0]       I_clk_en;
    logic [CHANNELS*WIDTH-1:0] I_div_ratio;
    logic                      I_sync;
    logic [CHANNELS-1:0]       O_div_clk;
    logic [CHANNELS-1:0]       O_tick;
    logic [CHANNELS-1:0]       O_active;

    modport master (
        output I_clk_en, I_div_ratio, I_sync,
        input  O_div_clk, O_tick, O_active
    );

    modport slave (
        input  I_clk_en, I_div_ratio, I_sync,
        output O_div_clk, O_tick, O_active
    );
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: BYPASS/RUN state, period counter, latched ratio and
// registered divided clock and tick.
`timescale 1ns/1ps
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             ref_clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] ratio,
    input  logic             sync,
    output logic             div_clk,
    output logic             tick,
    output chan_state_t      state
);
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] ratio_q;
    logic [WIDTH-1:0] high_q;
    logic             div_q;
    logic             tick_q;

    logic             start_ok;
    logic             at_end;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] high_next;

    assign start_ok  = en && (ratio >= WIDTH'(2));
    assign at_end    = (cnt == ratio_q - WIDTH'(1));
    assign cnt_inc   = cnt + WIDTH'(1);
    // High length is latched with the ratio so the per-cycle path is one compare.
    assign high_next = WIDTH'(high_len(WIDTH_MAX'(ratio)));

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state   <= BYPASS;
            cnt     <= '0;
            ratio_q <= '0;
            high_q  <= '0;
            div_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            case (state)
                BYPASS: begin
                    if (start_ok) begin
                        state   <= RUN;
                        ratio_q <= ratio;
                        high_q  <= high_next;
                        cnt     <= '0;
                        div_q   <= 1'b1;
                        tick_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (sync || at_end) begin
                        if (start_ok) begin
                            ratio_q <= ratio;
                            high_q  <= high_next;
                            cnt     <= '0;
                            div_q   <= 1'b1;
                            tick_q  <= 1'b1;
                        end else begin
                            state  <= BYPASS;
                            cnt    <= '0;
                            div_q  <= 1'b0;
                            tick_q <= 1'b0;
                        end
                    end else begin
                        cnt    <= cnt_inc;
                        div_q  <= (cnt_inc < high_q);
                        tick_q <= 1'b0;
                    end
                end
                default: state <= BYPASS;
            endcase
        end
    end

    // Bypass hands the reference clock straight through; this mux is not glitch-free.
    assign div_clk = (state == RUN) ? div_q : ref_clk;
    assign tick    = tick_q;
endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider: CHANNELS independent dividers sharing
// one reference clock, reset and sync pulse.
`timescale 1ns/1ps
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEFAULT,
    parameter int CHANNELS = 4
) (
    input  logic            I_ref_clk,
    input  logic            I_rst,
    clk_div_multi_if.slave  bus
);
    chan_state_t chan_state [CHANNELS];

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        clk_div_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .ref_clk (I_ref_clk),
            .rst     (I_rst),
            .en      (bus.I_clk_en[gi]),
            .ratio   (bus.I_div_ratio[gi*WIDTH +: WIDTH]),
            .sync    (bus.I_sync),
            .div_clk (bus.O_div_clk[gi]),
            .tick    (bus.O_tick[gi]),
            .state   (chan_state[gi])
        );

        assign bus.O_active[gi] = (chan_state[gi] == RUN);
    end
endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: per-cycle expected channel behaviour is
// written as strings (B=bypass, T=tick cycle, H=high, L=low) and checked by a monitor.
`timescale 1ns/1ps
module tb_clk_div_multi;
  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int W        = 2 * CHANNELS;

  logic clk = 1'b0;
  logic rst;

  clk_div_multi_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus();

  clk_div_multi #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) dut (
    .I_ref_clk (clk),
    .I_rst     (rst),
    .bus       (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;
  int mon_idx      = 0;

  logic [CHANNELS-1:0] en_v;
  logic [WIDTH-1:0]    ratio_v [CHANNELS];
  logic                sync_v;
  logic                rst_v;

  function automatic logic [1:0] enc(input byte c);
    case (c)
      "T":     return 2'd1;
      "H":     return 2'd2;
      "L":     return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // driver: apply stimulus on the falling edge, queue the response for the next rising edge
  task automatic step(input logic [W-1:0] e);
    @(negedge clk);
    rst = rst_v;
    bus.I_clk_en = en_v;
    for (int ch = 0; ch < CHANNELS; ch++) bus.I_div_ratio[ch*WIDTH +: WIDTH] = ratio_v[ch];
    bus.I_sync = sync_v;
    exp_q.push_back(e);
  endtask

  task automatic play(input string s0, input string s1, input string s2, input string s3);
    string s [CHANNELS];
    int n;
    logic [W-1:0] e;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    n = 0;
    for (int ch = 0; ch < CHANNELS; ch++) if (s[ch].len() > n) n = s[ch].len();
    for (int k = 0; k < n; k++) begin
      e = '0;
      for (int ch = 0; ch < CHANNELS; ch++)
        if (k < s[ch].len()) e[2*ch +: 2] = enc(s[ch].getc(k));
      step(e);
    end
  endtask

  // monitor / scoreboard
  initial begin : monitor
    logic [W-1:0] e;
    logic [1:0] code;
    logic [CHANNELS-1:0] et, ea, eh, el;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int ch = 0; ch < CHANNELS; ch++) begin
          code   = e[2*ch +: 2];
          et[ch] = (code == 2'd1);
          ea[ch] = (code != 2'd0);
          eh[ch] = (code != 2'd3);
          el[ch] = (code == 2'd1) || (code == 2'd2);
        end
        tests_run++;
        if ({bus.O_tick, bus.O_active, bus.O_div_clk} !== {et, ea, eh}) begin
          tests_failed++;
          $display("FAIL rise_phase cycle %0d: tick/active/div got %b/%b/%b want %b/%b/%b",
                   mon_idx, bus.O_tick, bus.O_active, bus.O_div_clk, et, ea, eh);
        end
        @(negedge clk); #1;
        tests_run++;
        if (bus.O_div_clk !== el) begin
          tests_failed++;
          $display("FAIL fall_phase cycle %0d: div got %b want %b", mon_idx, bus.O_div_clk, el);
        end
        mon_idx++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    tests_failed++;
    $display("FAIL watchdog: bench did not complete, %0d expectations pending", exp_q.size());
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin : stimulus
    string s2, s3;
    int guard;
    rst = 1'b1;
    bus.I_clk_en = '0;
    bus.I_div_ratio = '0;
    bus.I_sync = 1'b0;
    rst_v = 1'b1; en_v = '0; sync_v = 1'b0;
    for (int ch = 0; ch < CHANNELS; ch++) ratio_v[ch] = '0;

    // reset state
    play("BBB", "BBB", "BBB", "BBB");

    // even R=4, odd R=5, bypass via R=0 and R=1
    rst_v = 1'b0; en_v = 4'b1111;
    ratio_v[0] = 8'd4; ratio_v[1] = 8'd5; ratio_v[2] = 8'd0; ratio_v[3] = 8'd1;
    play("THLLTHLLTHLL", "THHLLTHHLLTH", "BBBBBBBBBBBB", "BBBBBBBBBBBB");

    // reset mid-period overrides enable
    rst_v = 1'b1;
    play("BB", "BB", "BB", "BB");
    rst_v = 1'b0; en_v = 4'b0000;
    play("BB", "BB", "BB", "BB");

    // odd R=3, then enable drop finishes the period
    en_v = 4'b0010; ratio_v[1] = 8'd3;
    play("", "THLTHLT", "", "");
    en_v = 4'b0000;
    play("", "HLBB", "", "");

    // ratio change 4->6 at cnt=1, then disable
    en_v = 4'b0001; ratio_v[0] = 8'd4;
    play("TH", "", "", "");
    ratio_v[0] = 8'd6;
    play("LLTHHLLLT", "", "", "");
    en_v = 4'b0000;
    play("HHLLLB", "", "", "");

    // R=8, enable drops at cnt=1
    en_v = 4'b0001; ratio_v[0] = 8'd8;
    play("TH", "", "", "");
    en_v = 4'b0000;
    play("HHLLLLBB", "", "", "");

    // sync realigns R=3 and R=4 channels
    en_v = 4'b0011; ratio_v[0] = 8'd3; ratio_v[1] = 8'd4;
    play("THLTHL", "THLLTH", "", "");
    sync_v = 1'b1;
    play("T", "T", "", "");
    sync_v = 1'b0;
    play("HLTHLT", "HLLTHL", "", "");
    sync_v = 1'b1;
    play("T", "T", "", "");
    sync_v = 1'b0;
    play("H", "H", "", "");
    rst_v = 1'b1;
    play("B", "B", "B", "B");
    rst_v = 1'b0; en_v = 4'b0000;
    play("BB", "BB", "BB", "BB");

    // smallest and largest ratios
    en_v = 4'b1100; ratio_v[2] = 8'd2; ratio_v[3] = 8'd255;
    s2 = ""; s3 = "";
    for (int k = 0; k < 257; k++) begin
      s2 = {s2, (k % 2 == 0) ? "T" : "L"};
      if (k == 0 || k == 255) s3 = {s3, "T"};
      else if (k < 128 || k == 256) s3 = {s3, "H"};
      else s3 = {s3, "L"};
    end
    play("", "", s2, s3);
    rst_v = 1'b1;
    play("B", "B", "B", "B");
    rst_v = 1'b0; en_v = 4'b0000;
    play("BB", "BB", "BB", "BB");

    // drain
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    #2;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: pending %0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel integer clock divider: the next generation of the single-channel `I_ref_clk`/`I_div_ratio` divider. It derives `CHANNELS` independent divided clocks from one reference clock, each with its own enable and ratio. Ratio and enable changes take effect only at period boundaries, and channels can be phase-aligned with a common sync pulse. It sits in the clock-generation area and feeds the slower-domain logic, such as the serial CRC and UART paths.

## Interface
- `WIDTH`, 8: ratio width per channel.
- `CHANNELS`, 4: number of independent divider channels.
- `I_ref_clk`  in  1: reference clock; all logic runs on its rising edge.
- `I_rst`  in  1: synchronous, active-high reset.
- `I_clk_en`  in  CHANNELS: per-channel enable; bit i belongs to channel i.
- `I_div_ratio`  in  CHANNELS*WIDTH: packed ratios; channel i uses bits `[i*WIDTH +: WIDTH]`.
- `I_sync`  in  1: single-cycle pulse that restarts all running channels at phase 0.
- `O_div_clk`  out  CHANNELS: divided clock per channel.
- `O_tick`  out  CHANNELS: one-cycle pulse in the first cycle of each divided period.
- `O_active`  out  CHANNELS: 1 while the channel is in RUN.

## Operation
- Each channel has two states: BYPASS and RUN.
- **BYPASS:**
  - `O_div_clk[i]` = `I_ref_clk`, through a combinational mux.
  - `O_tick[i]` = 0 and `O_active[i]` = 0.
  - Transition BYPASS→RUN when `I_clk_en[i]`=1 and ratio R >= 2 are sampled on an edge.
  - On that transition, latch R into `ratio_q`, set cnt=0, and start the period.
- **RUN:**
  - cnt counts 0..`ratio_q`-1, then wraps.
  - High phase H = ceil(`ratio_q`/2) cycles; low phase L = floor(`ratio_q`/2) cycles. Odd ratios therefore have one extra high cycle.
  - `O_div_clk[i]` = registered (cnt < H). `O_tick[i]` = registered (cnt == 0).
- **Period boundary** (cnt == `ratio_q`-1), re-sample enable and ratio:
  - en=1 and R>=2: latch R and continue with cnt=0.
  - en=0 or R<2: go to BYPASS.
- Enable or ratio changes mid-period never truncate or stretch the current period.
- `I_sync`=1:
  - Every RUN channel sets cnt=0 and re-latches its ratio on the same edge. The BYPASS/RUN decision is the same as at a boundary.
  - BYPASS channels ignore `I_sync` and enter RUN only through the normal enable/ratio condition.
  - If `I_sync` and a boundary coincide, `I_sync` wins; the result is identical.
- **Ratio arithmetic:** unsigned, full WIDTH; maximum ratio is 2^WIDTH-1. Ratios 0 and 1 are treated as bypass.
- **Glitches:** BYPASS↔RUN switching through the mux is not glitch-free; consumers must tolerate that transition. Divided-to-divided transitions are always clean.

## Timing
- **Reset** (edge with `I_rst`=1):
  - All channels go to BYPASS; cnt=0, `ratio_q`=0.
  - `O_active`=0, `O_tick`=0, divided register=0.
  - `O_div_clk` follows `I_ref_clk` during and after reset until activation.
- Reset asserted mid-operation takes effect on the next edge and overrides `I_sync` and enable.
- **Activation:** en and R sampled at edge t0. From t0:
  - `O_active`=1, `O_tick`=1, and `O_div_clk`=1 for H cycles, then 0 for L cycles.
  - `O_tick` repeats every `ratio_q` cycles.
- **Deactivation:** the first edge after the final cycle of the current period. `O_active` falls at that edge.
- **Latency:** 0 cycles from sampling edge to output. Outputs are registered on the sampling edge; there is no extra pipeline stage.
- **Timing path:** R = 2^WIDTH-1 must meet timing without a multi-cycle path.

## Structure
- Package `clk_div_pkg` holds:
  - The `WIDTH` default.
  - A state enum {BYPASS, RUN}.
  - Function `high_len(R)` returning ceil(R/2).
- Sub-module `clk_div_chan` implements one channel: state, cnt, `ratio_q`, and output registers.
- Top module `clk_div_multi` generates `CHANNELS` instances, slices `I_div_ratio`, and fans out `I_sync`.

## Test plan
- **Even ratio:** reset, ch0 en=1 R=4 → `O_div_clk` pattern 1,1,0,0 repeating; `O_tick` every 4 cycles; `O_active`=1 from the activation edge.
- **Odd ratio:** ch1 R=5 → high 3 cycles, low 2 cycles; R=3 → high 2, low 1.
- **Bypass:** en=0, or R=0/1 → `O_div_clk` identical to `I_ref_clk`; `O_tick`=0; `O_active`=0.
- **Ratio change mid-period:** R changes 4→6 at cnt=1 → current period completes as 2/2, next period is 3/3, `O_tick` spacing goes 4 then 6.
- **Enable drop:** R=8 running, en drops at cnt=1 → channel stays RUN through cnt=7, then BYPASS; `O_active` falls at the following edge.
- **Sync and reset:**
  - ch0 R=3 and ch1 R=4 running; pulse `I_sync` → both channels have cnt=0 with coincident `O_tick` on that edge.
  - Assert `I_rst` mid-period → all outputs take their reset values on the next edge.
